// File: rtl/word_unpacker_pkg.sv
// Shared state encoding and word/byte geometry for the word unpacker.
package word_unpacker_pkg;

   typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

   localparam int unsigned DefWordW     = 16;
   localparam int unsigned DefByteW     = 8;
   localparam int unsigned DefLenW      = 16;
   localparam int unsigned BytesPerWord = DefWordW / DefByteW;

   function automatic int unsigned bytes_per_word(input int unsigned w, input int unsigned b);
      return w / b;
   endfunction

   // Index counter needs at least one bit even when a word holds a single byte.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/word_unpacker.sv
// Pops W-bit words from an upstream FIFO and emits them as B-bit bytes, MSB first,
// for a burst of len words started by a one-cycle start pulse.
module word_unpacker
   import word_unpacker_pkg::*;
#(
   parameter int unsigned W  = DefWordW,
   parameter int unsigned B  = DefByteW,
   parameter int unsigned LW = DefLenW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [LW-1:0] len,
   output logic          busy,
   output logic          done,
   input  logic          in_ready,
   input  logic [W-1:0]  in_data,
   output logic          in_trigger,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [B-1:0]  out_data
);

   localparam int unsigned Bpw  = bytes_per_word(W, B);
   localparam int unsigned IdxW = idx_width(Bpw);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(Bpw - 1);

   state_e          state_q;
   logic [W-1:0]    shift_q;
   logic [LW-1:0]   remaining_q;
   logic [IdxW-1:0] idx_q;
   logic            busy_q;
   logic            done_q;

   logic last_hs;
   logic more_words;

   assign last_hs    = (state_q == StShift) && out_ready && (idx_q == LastIdx);
   assign more_words = (remaining_q != '0);

   // Refill straight from the last-byte handshake so back-to-back words have no bubble.
   assign in_trigger = in_ready && ((state_q == StLoad) || (last_hs && more_words));
   assign out_valid  = (state_q == StShift);
   assign out_data   = shift_q[W-1 -: B];
   assign busy       = busy_q;
   assign done       = done_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         shift_q     <= '0;
         remaining_q <= '0;
         idx_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  if (len != '0) begin
                     remaining_q <= len;
                     busy_q      <= 1'b1;
                     state_q     <= StLoad;
                  end else begin
                     done_q <= ~done_q;
                  end
               end
            end
            StLoad: begin
               if (in_ready) begin
                  shift_q     <= in_data;
                  remaining_q <= remaining_q - LW'(1);
                  idx_q       <= '0;
                  state_q     <= StShift;
               end
            end
            StShift: begin
               if (out_ready) begin
                  if (idx_q != LastIdx) begin
                     shift_q <= shift_q << B;
                     idx_q   <= idx_q + IdxW'(1);
                  end else if (more_words) begin
                     if (in_ready) begin
                        shift_q     <= in_data;
                        remaining_q <= remaining_q - LW'(1);
                        idx_q       <= '0;
                     end else begin
                        state_q <= StLoad;
                     end
                  end else begin
                     done_q  <= ~done_q;
                     busy_q  <= 1'b0;
                     state_q <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/word_unpacker.md
WORD_UNPACKER -- requirements
Module: word_unpacker

Interface
REQ-001 Parameter W, default 16, FIFO word width in bits; SHALL be an integer multiple of B.
REQ-002 Parameter B, default 8, output byte width in bits.
REQ-003 Parameter LW, default 16, width of the burst-length port.
REQ-004 clk  input  1  sole clock; every register is rising-edge clocked.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 start  input  1  one-cycle pulse that begins a burst.
REQ-007 len  input  LW  words per burst, sampled on start.
REQ-008 busy  output  1  high while a burst is in progress.
REQ-009 done  output  1  toggle; inverts once per completed burst.
REQ-010 in_ready  input  1  upstream FIFO read-ready (data available).
REQ-011 in_data  input  W  upstream FIFO read data, valid whenever in_ready=1.
REQ-012 in_trigger  output  1  upstream FIFO read trigger; pops one word on the clk edge it is high.
REQ-013 out_valid  output  1  out_data holds a valid byte.
REQ-014 out_ready  input  1  downstream accepts the byte.
REQ-015 out_data  output  B  current byte, most significant byte of the word first.

Function
REQ-016 States SHALL be IDLE, LOAD and SHIFT.
REQ-017 IDLE: start=1 and len!=0 -> latch remaining=len, busy=1, go to LOAD.
REQ-018 IDLE: start=1 and len=0 -> toggle done on the next edge, no FIFO read, stay in IDLE.
REQ-019 start while busy=1 SHALL be ignored.
REQ-020 LOAD: in_trigger = in_ready (combinational).
REQ-021 LOAD, on an edge with in_ready=1: capture in_data into the shift register, decrement remaining, reset byte index to 0, go to SHIFT.
REQ-022 SHIFT: out_valid=1; out_data = shift[W-1 -: B].
REQ-023 SHIFT, on handshake (out_valid & out_ready) with byte index < W/B-1: shift left by B, increment byte index.
REQ-024 SHIFT, handshake on the last byte with remaining!=0 and in_ready=1: in_trigger=1 in that same cycle and load directly, so there is no bubble between words.
REQ-025 SHIFT, handshake on the last byte with remaining!=0 and in_ready=0: go to LOAD.
REQ-026 SHIFT, handshake on the last byte with remaining=0: toggle done, busy=0, go to IDLE.
REQ-027 in_trigger SHALL never be high when in_ready=0 or outside LOAD/last-byte-handshake.
REQ-028 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-029 Latency: start at cycle 0 with in_ready=1 -> in_trigger in cycle 1 -> first out_valid in cycle 2.
REQ-030 Throughput: with in_ready=out_ready=1 continuously, one byte per cycle sustained.
REQ-031 remaining arithmetic SHALL be LW bits unsigned; len=2^LW-1 SHALL complete without wrap.
REQ-032 An empty FIFO (in_ready=0) mid-burst SHALL stall in LOAD indefinitely with out_valid=0.

Reset
REQ-033 rst=1 SHALL immediately force: state=IDLE, busy=0, out_valid=0, in_trigger=0, done=0, shift register=0, counters=0.
REQ-034 Reset mid-burst SHALL abandon the burst without toggling done; after release, the next start begins a fresh burst.

Structure
REQ-035 State encodings and the derived constant W/B (bytes per word) SHALL live in a shared header/package.
REQ-036 No sub-module; the block is one state machine plus a shift register and two counters.

Verification
REQ-037 len=3, FIFO preloaded 0x1234,0x5678,0x9ABC, out_ready=1 -> bytes 12 34 56 78 9A BC on 6 consecutive cycles, done toggles once, 3 triggers.
REQ-038 len=2, out_ready toggles 1/0 each cycle -> same byte order, out_data stable during stalls, 4 bytes in 8 cycles.
REQ-039 len=4, FIFO holds 1 word, 3 more written 20 cycles later -> stall in LOAD with out_valid=0, then completes; done toggles once.
REQ-040 start with len=0 -> done toggles 1 cycle later, in_trigger never high.
REQ-041 rst asserted after 3 bytes of a len=4 burst -> outputs cleared asynchronously, done unchanged; new len=1 burst emits 2 bytes.
REQ-042 Second start during a busy burst -> ignored; byte count and trigger count match the first len only.
